// File: rtl/noc_packetizer_pkg.sv
// noc_packetizer_pkg
//   Shared definitions for the cache-to-NoC packetizer: coherence message
//   encodings, flit type codes, the data-carrying message predicate, the FSM
//   state type and the bit offsets of the fields inside a head flit payload.
package noc_packetizer_pkg;

  // Widths these encodings and offsets are laid out for.
  localparam int MSG_W    = 4;
  localparam int ID_W     = 2;
  localparam int LEN_BITS = 3;

  // Coherence message encodings.
  localparam logic [MSG_W-1:0] NoMsg    = 4'd0;
  localparam logic [MSG_W-1:0] GetS     = 4'd1;
  localparam logic [MSG_W-1:0] GetM     = 4'd2;
  localparam logic [MSG_W-1:0] PutS     = 4'd3;
  localparam logic [MSG_W-1:0] PutE     = 4'd4;
  localparam logic [MSG_W-1:0] PutM     = 4'd5;
  localparam logic [MSG_W-1:0] InvAck   = 4'd6;
  localparam logic [MSG_W-1:0] Inv      = 4'd7;
  localparam logic [MSG_W-1:0] FwdGetS  = 4'd8;
  localparam logic [MSG_W-1:0] FwdGetM  = 4'd9;
  localparam logic [MSG_W-1:0] RespPutM = 4'd10;
  localparam logic [MSG_W-1:0] DataS    = 4'd11;
  localparam logic [MSG_W-1:0] DataE    = 4'd12;
  localparam logic [MSG_W-1:0] DataM    = 4'd13;
  localparam logic [MSG_W-1:0] PutAck   = 4'd14;

  // Flit type codes (top two bits of every flit).
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  // Head payload layout, LSB first: len, msg, source ID, destination ID.
  localparam int HEAD_LEN_LSB  = 0;
  localparam int HEAD_MSG_LSB  = HEAD_LEN_LSB + LEN_BITS;
  localparam int HEAD_SRC_LSB  = HEAD_MSG_LSB + MSG_W;
  localparam int HEAD_DEST_LSB = HEAD_SRC_LSB + ID_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // Messages that carry a full cache line after the address.
  function automatic logic msg_has_data(input logic [MSG_W-1:0] msg);
    return (msg == PutM) || (msg == RespPutM) || (msg == DataS) ||
           (msg == DataE) || (msg == DataM);
  endfunction

endpackage

// File: rtl/noc_packetizer.sv
// noc_packetizer
//   Captures one coherence message from the cache-NoC interface and sends it
//   to the router as HEAD / ADDR / [DATA x CACHE_WORDS] flits over a
//   valid/ready link. One message in flight; inputs ignored while busy.
//
// Ports
//   clock            system clock
//   reset            synchronous, active-low
//   msg_in           message (NoMsg = no request), captured when idle
//   address_in       message address
//   data_in          cache line, word 0 in the low DATA_WIDTH bits
//   dest_id          destination node ID
//   packetizer_busy  high while a packet is held or being sent
//   flit_out         {type[1:0], payload}
//   flit_valid       flit_out valid (registered state, independent of ready)
//   flit_ready       router accepts the flit this cycle
//
// MSG_BITS and ID_BITS must match the package widths the head offsets use.
module noc_packetizer
  import noc_packetizer_pkg::*;
#(
  parameter int MSG_BITS          = 4,
  parameter int ADDRESS_BITS      = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int ID_BITS           = 2,
  parameter int SRC_ID            = 0,
  parameter int FLIT_WIDTH        = DATA_WIDTH + 2
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [MSG_BITS-1:0]                          msg_in,
  input  logic [ADDRESS_BITS-1:0]                      address_in,
  input  logic [DATA_WIDTH*(1<<CACHE_OFFSET_BITS)-1:0] data_in,
  input  logic [ID_BITS-1:0]                           dest_id,
  output logic                                         packetizer_busy,
  output logic [FLIT_WIDTH-1:0]                        flit_out,
  output logic                                         flit_valid,
  input  logic                                         flit_ready
);

  localparam int CACHE_WORDS = 1 << CACHE_OFFSET_BITS;
  localparam logic [CACHE_OFFSET_BITS-1:0] LAST_WORD = CACHE_OFFSET_BITS'(CACHE_WORDS - 1);
  localparam logic [LEN_BITS-1:0] LEN_DATA   = LEN_BITS'(CACHE_WORDS + 1);
  localparam logic [LEN_BITS-1:0] LEN_NODATA = LEN_BITS'(1);

  state_t                                 state_reg, state_next;
  logic [CACHE_OFFSET_BITS-1:0]           word_cnt_reg, word_cnt_next;
  logic [MSG_BITS-1:0]                    msg_reg;
  logic [ADDRESS_BITS-1:0]                addr_reg;
  logic [DATA_WIDTH*CACHE_WORDS-1:0]      line_reg;
  logic [ID_BITS-1:0]                     dest_reg;

  logic                                   accept;
  logic                                   fire;
  logic                                   has_data;
  logic [DATA_WIDTH-1:0]                  line_words [CACHE_WORDS];
  logic [DATA_WIDTH-1:0]                  head_word;

  // Split the captured line into words for the data-phase mux.
  generate
    for (genvar gi = 0; gi < CACHE_WORDS; gi++) begin : g_words
      assign line_words[gi] = line_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign accept          = (state_reg == ST_IDLE) && (msg_in != NoMsg);
  assign flit_valid      = (state_reg != ST_IDLE);
  assign packetizer_busy = (state_reg != ST_IDLE);
  assign fire            = flit_valid && flit_ready;
  assign has_data        = msg_has_data(msg_reg);

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_HEAD;
      ST_HEAD: if (fire)   state_next = ST_ADDR;
      ST_ADDR: begin
        if (fire) begin
          word_cnt_next = '0;
          state_next    = has_data ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fire) begin
          word_cnt_next = word_cnt_reg + 1'b1;
          if (word_cnt_reg == LAST_WORD) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      msg_reg      <= '0;
      addr_reg     <= '0;
      line_reg     <= '0;
      dest_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      if (accept) begin
        msg_reg  <= msg_in;
        addr_reg <= address_in;
        line_reg <= data_in;
        dest_reg <= dest_id;
      end
    end
  end

  always_comb begin
    head_word = '0;
    head_word[HEAD_LEN_LSB  +: LEN_BITS] = has_data ? LEN_DATA : LEN_NODATA;
    head_word[HEAD_MSG_LSB  +: MSG_BITS] = msg_reg;
    head_word[HEAD_SRC_LSB  +: ID_BITS]  = ID_BITS'(SRC_ID);
    head_word[HEAD_DEST_LSB +: ID_BITS]  = dest_reg;
  end

  // Output is a pure mux of registered state, so it is stable under backpressure.
  always_comb begin
    flit_out = '0;
    case (state_reg)
      ST_HEAD: flit_out = {HEAD, head_word};
      ST_ADDR: flit_out = {(has_data ? BODY : TAIL), addr_reg};
      ST_DATA: flit_out = {((word_cnt_reg == LAST_WORD) ? TAIL : BODY),
                           line_words[word_cnt_reg]};
      default: flit_out = '0;
    endcase
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer
//   Directed bench for noc_packetizer: reset, non-data packet, data packet,
//   backpressure, back-to-back messages and reset in the middle of a packet.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_noc_packetizer;
  import noc_packetizer_pkg::*;

  logic         clock;
  logic         reset;
  logic [3:0]   msg_in;
  logic [31:0]  address_in;
  logic [127:0] data_in;
  logic [1:0]   dest_id;
  logic         packetizer_busy;
  logic [33:0]  flit_out;
  logic         flit_valid;
  logic         flit_ready;

  int checks   = 0;
  int failures = 0;

  noc_packetizer dut (
    .clock           (clock),
    .reset           (reset),
    .msg_in          (msg_in),
    .address_in      (address_in),
    .data_in         (data_in),
    .dest_id         (dest_id),
    .packetizer_busy (packetizer_busy),
    .flit_out        (flit_out),
    .flit_valid      (flit_valid),
    .flit_ready      (flit_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; msg_in = PutM; address_in = 32'h0000_1000;
    data_in = 128'h1; dest_id = 2'd1; flit_ready = 1'b1;
    step(); step();
    checks++;
    if (flit_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", flit_valid); end
    checks++;
    if (packetizer_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", packetizer_busy); end
    checks++;
    if (flit_out !== 34'h0) begin failures++; $display("FAIL reset_flit got=%h exp=0", flit_out); end
    // Release with NoMsg: PutM seen during reset must not have been captured.
    reset = 1'b1; msg_in = NoMsg;
    step(); step();
    checks++;
    if (packetizer_busy !== 1'b0 || flit_valid !== 1'b0)
      begin failures++; $display("FAIL nomsg_idle got busy=%b valid=%b exp=0/0", packetizer_busy, flit_valid); end
    $display("test_reset done");
  endtask

  task automatic test_non_data();
    logic [33:0] exp_f [2];
    exp_f[0] = 34'h1_0000_0031;  // HEAD: msg 6 (InvAck), len 1
    exp_f[1] = 34'h3_0000_3000;  // TAIL: address
    msg_in = InvAck; address_in = 32'h0000_3000; dest_id = 2'd0; flit_ready = 1'b1;
    step();
    msg_in = NoMsg;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flit_out !== exp_f[i] || flit_valid !== 1'b1 || packetizer_busy !== 1'b1)
        begin failures++; $display("FAIL nodata_flit%0d got=%h v=%b b=%b exp=%h v=1 b=1", i, flit_out, flit_valid, packetizer_busy, exp_f[i]); end
      step();
    end
    checks++;
    if (packetizer_busy !== 1'b0 || flit_valid !== 1'b0)
      begin failures++; $display("FAIL nodata_end got busy=%b valid=%b exp=0/0", packetizer_busy, flit_valid); end
    $display("test_non_data done");
  endtask

  // Shared by the data and backpressure scenarios; stall_idx < 0 means no stall.
  task automatic run_data_packet(input string name, input int stall_idx);
    logic [33:0] exp_f [6];
    exp_f[0] = 34'h1_0000_0655;  // HEAD: dest 3, msg 10 (RespPutM), len 5
    exp_f[1] = 34'h2_0000_2000;
    exp_f[2] = 34'h2_2000_0004;
    exp_f[3] = 34'h2_2000_0003;
    exp_f[4] = 34'h2_2000_0002;
    exp_f[5] = 34'h3_2000_0001;
    msg_in = RespPutM; address_in = 32'h0000_2000; dest_id = 2'd3; flit_ready = 1'b1;
    data_in = 128'h20000001_20000002_20000003_20000004;
    step();
    // Post-acceptance input changes must not leak into the packet.
    msg_in = NoMsg; address_in = 32'hDEAD_BEEF; data_in = {4{32'hBAD0_BAD0}}; dest_id = 2'd0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (flit_out !== exp_f[i] || flit_valid !== 1'b1 || packetizer_busy !== 1'b1)
        begin failures++; $display("FAIL %s_flit%0d got=%h v=%b b=%b exp=%h v=1 b=1", name, i, flit_out, flit_valid, packetizer_busy, exp_f[i]); end
      if (i == stall_idx) begin
        flit_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          checks++;
          if (flit_out !== exp_f[i] || flit_valid !== 1'b1 || packetizer_busy !== 1'b1)
            begin failures++; $display("FAIL %s_stall%0d got=%h v=%b b=%b exp=%h v=1 b=1", name, s, flit_out, flit_valid, packetizer_busy, exp_f[i]); end
        end
        flit_ready = 1'b1;
      end
      step();
    end
    checks++;
    if (packetizer_busy !== 1'b0 || flit_valid !== 1'b0 || flit_out !== 34'h0)
      begin failures++; $display("FAIL %s_end got busy=%b valid=%b flit=%h exp=0/0/0", name, packetizer_busy, flit_valid, flit_out); end
  endtask

  task automatic test_data();
    run_data_packet("data", -1);
    $display("test_data done");
  endtask

  task automatic test_backpressure();
    run_data_packet("bp", 3);
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_a [2];
    logic [33:0] exp_b [2];
    exp_a[0] = 34'h1_0000_0031;  // InvAck, dest 0, len 1
    exp_a[1] = 34'h3_0000_3000;
    exp_b[0] = 34'h1_0000_0421;  // PutE (4), dest 2, len 1
    exp_b[1] = 34'h3_0000_4000;
    msg_in = InvAck; address_in = 32'h0000_3000; dest_id = 2'd0; flit_ready = 1'b1;
    step();
    msg_in = PutE; address_in = 32'h0000_4000; dest_id = 2'd2;  // held while busy
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flit_out !== exp_a[i] || flit_valid !== 1'b1)
        begin failures++; $display("FAIL b2b_first%0d got=%h v=%b exp=%h v=1", i, flit_out, flit_valid, exp_a[i]); end
      step();
    end
    checks++;
    if (packetizer_busy !== 1'b0 || flit_valid !== 1'b0)
      begin failures++; $display("FAIL b2b_gap got busy=%b valid=%b exp=0/0", packetizer_busy, flit_valid); end
    step();
    msg_in = NoMsg;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flit_out !== exp_b[i] || flit_valid !== 1'b1)
        begin failures++; $display("FAIL b2b_second%0d got=%h v=%b exp=%h v=1", i, flit_out, flit_valid, exp_b[i]); end
      step();
    end
    checks++;
    if (packetizer_busy !== 1'b0)
      begin failures++; $display("FAIL b2b_end got busy=%b exp=0", packetizer_busy); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_packet();
    logic [33:0] exp_c [2];
    exp_c[0] = 34'h1_0000_0231;  // InvAck, dest 1, len 1
    exp_c[1] = 34'h3_0000_5000;
    msg_in = RespPutM; address_in = 32'h0000_2000; dest_id = 2'd3; flit_ready = 1'b1;
    data_in = 128'h20000001_20000002_20000003_20000004;
    step();
    msg_in = NoMsg;
    step(); step(); step();   // now presenting the second data flit
    checks++;
    if (flit_out !== 34'h2_2000_0003)
      begin failures++; $display("FAIL rmid_pre got=%h exp=220000003", flit_out); end
    reset = 1'b0;
    step();
    checks++;
    if (flit_valid !== 1'b0 || packetizer_busy !== 1'b0 || flit_out !== 34'h0)
      begin failures++; $display("FAIL rmid_abort got valid=%b busy=%b flit=%h exp=0/0/0", flit_valid, packetizer_busy, flit_out); end
    reset = 1'b1;
    step();
    checks++;
    if (flit_valid !== 1'b0)
      begin failures++; $display("FAIL rmid_notail got valid=%b exp=0", flit_valid); end
    msg_in = InvAck; address_in = 32'h0000_5000; dest_id = 2'd1;
    step();
    msg_in = NoMsg;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flit_out !== exp_c[i] || flit_valid !== 1'b1)
        begin failures++; $display("FAIL rmid_new%0d got=%h v=%b exp=%h v=1", i, flit_out, flit_valid, exp_c[i]); end
      step();
    end
    checks++;
    if (packetizer_busy !== 1'b0)
      begin failures++; $display("FAIL rmid_end got busy=%b exp=0", packetizer_busy); end
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    reset = 1'b0; msg_in = NoMsg; address_in = '0; data_in = '0;
    dest_id = '0; flit_ready = 1'b0;
    test_reset();
    test_non_data();
    test_data();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
